// File: rtl/mul_accum_pkg.sv
// Shared types and default widths for the product accumulator stage.
package mul_accum_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  localparam int IN_W_DEF    = 32;
  localparam int ACC_W_DEF   = 40;
  localparam int ACC_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/mul_accum_stage_if.sv
// Handshake bundle for the accumulator: product input side and total output side.
// The master drives products and out_ready; the slave (the stage) drives in_ready and the result.
interface mul_accum_stage_if import mul_accum_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             flush;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, flush, clr, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, flush, clr, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/mul_accum_add.sv
// Combinational accumulator adder: zero-extends the product, adds it to the running total
// and reports the carry-out of the ACC_W-bit add.
// Optional macro ACCUM_SAT_EN: when defined, a carry clamps the sum to all ones; otherwise it wraps.
module mul_accum_add import mul_accum_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] raw;

  // One extra bit captures the carry-out; a saturated total stays saturated because any further nonzero add carries again
  always_comb begin
    raw   = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, addend};
    carry = raw[ACC_W];
`ifdef ACCUM_SAT_EN
    sum   = carry ? '1 : raw[ACC_W-1:0];
`else
    sum   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mul_accum_stage.sv
// Product accumulator: sums groups of ACC_LEN unsigned products into a total and holds
// each total in a single-entry output register with backpressure. flush closes a group
// early, clr discards a partial group. Optional macro ACCUM_SAT_EN selects saturating adds.
module mul_accum_stage import mul_accum_pkg::*; #(
  parameter int IN_W    = IN_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int ACC_LEN = ACC_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              resetn,
  mul_accum_stage_if.slave bus
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;
  logic             base_ovf;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [ACC_W-1:0] next_acc;
  logic [CNT_W-1:0] next_cnt;
  logic             next_ovf;
  logic             in_xfer;
  logic             out_xfer;
  logic             close;

  // The stage can take a product whenever the output register is empty or being drained this cycle
  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  mul_accum_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (base_acc),
    .addend (bus.in_data),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  // Next group state: clr restarts from zero (so a same-cycle product begins a fresh group), then the product is folded in
  always_comb begin
    in_xfer  = bus.in_valid && bus.in_ready;
    out_xfer = bus.out_valid && bus.out_ready;
    base_acc = (bus.clr || state == IDLE) ? '0 : acc;
    base_cnt = (bus.clr || state == IDLE) ? '0 : count;
    base_ovf = bus.clr ? 1'b0 : ovf;
    next_cnt = base_cnt + CNT_W'(in_xfer);
    next_acc = in_xfer ? add_sum : base_acc;
    next_ovf = base_ovf | (in_xfer & add_carry);
    close    = !bus.clr && (next_cnt != '0) &&
               ((in_xfer && next_cnt == CNT_W'(ACC_LEN)) || (bus.flush && bus.in_ready));
  end

  // Group FSM, counter and output register; a close loads the total and restarts the group in the same edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      acc           <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (close) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= next_acc;
      bus.out_count <= next_cnt;
      bus.out_ovf   <= next_ovf;
      acc           <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      state         <= IDLE;
    end else begin
      if (out_xfer) begin
        bus.out_valid <= 1'b0;
      end
      acc   <= next_acc;
      count <= next_cnt;
      ovf   <= next_ovf;
      state <= (next_cnt == '0) ? IDLE : ACCUM;
    end
  end

endmodule

// File: tb/tb_mul_accum_stage.sv
// Directed testbench for mul_accum_stage: one main instance (40-bit, groups of 16) plus two
// 33-bit instances (groups of 2 and 3) for the carry-out cases. Honours ACCUM_SAT_EN if defined.
module tb_mul_accum_stage;
  import mul_accum_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  logic [39:0] q_data[$];
  logic [15:0] q_cnt[$];
  logic        q_ovf[$];

  mul_accum_stage_if #(.IN_W(32), .ACC_W(40), .CNT_W(16)) m ();
  mul_accum_stage_if #(.IN_W(32), .ACC_W(33), .CNT_W(16)) a ();
  mul_accum_stage_if #(.IN_W(32), .ACC_W(33), .CNT_W(16)) b ();

  mul_accum_stage #(.IN_W(32), .ACC_W(40), .ACC_LEN(16), .CNT_W(16)) dut_main (
    .clk(clk), .resetn(resetn), .bus(m)
  );
  mul_accum_stage #(.IN_W(32), .ACC_W(33), .ACC_LEN(2), .CNT_W(16)) dut_len2 (
    .clk(clk), .resetn(resetn), .bus(a)
  );
  mul_accum_stage #(.IN_W(32), .ACC_W(33), .ACC_LEN(3), .CNT_W(16)) dut_len3 (
    .clk(clk), .resetn(resetn), .bus(b)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Record every total the main instance hands downstream
  always @(posedge clk) begin
    if (resetn && m.out_valid && m.out_ready) begin
      q_data.push_back(m.out_data);
      q_cnt.push_back(m.out_count);
      q_ovf.push_back(m.out_ovf);
    end
  end

  // Hard stop in case something stalls beyond every local bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_main();
    m.in_valid = 1'b0;
    m.in_data  = '0;
    m.flush    = 1'b0;
    m.clr      = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic fl, input logic cl);
    int k;
    m.in_valid = 1'b1;
    m.in_data  = d;
    m.flush    = fl;
    m.clr      = cl;
    k = 0;
    while (!m.in_ready && k < 100) begin
      tick(1);
      k++;
    end
    if (!m.in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", m.in_ready, k);
    end
    tick(1);
    idle_main();
  endtask

  task automatic pop_total(output logic ok, output logic [39:0] d, output logic [15:0] c, output logic o);
    ok = (q_data.size() != 0);
    d  = '0;
    c  = '0;
    o  = 1'b0;
    if (ok) begin
      d = q_data.pop_front();
      c = q_cnt.pop_front();
      o = q_ovf.pop_front();
    end
  endtask

  task automatic test_reset();
    logic ok;
    m.in_valid  = 1'b1;
    m.in_data   = 32'd123;
    m.flush     = 1'b0;
    m.clr       = 1'b0;
    m.out_ready = 1'b1;
    tick(3);
    tests++;
    if (m.out_valid !== 1'b0 || m.out_data !== 40'd0 || m.out_count !== 16'd0 || m.out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: valid=%0b data=%0d count=%0d ovf=%0b, required 0/0/0/0",
               m.out_valid, m.out_data, m.out_count, m.out_ovf);
    end
    tests++;
    if (m.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_in_ready: got %0b, required 1", m.in_ready);
    end
    idle_main();
    resetn = 1'b1;
    tick(4);
    ok = (q_data.size() == 0) && (m.out_valid === 1'b0);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL reset_spurious: totals=%0d out_valid=%0b, required 0/0", q_data.size(), m.out_valid);
    end
  endtask

  task automatic test_full_group();
    for (int i = 0; i < 16; i++) send(32'd1000, 1'b0, 1'b0);
    tests++;
    if (m.out_valid !== 1'b1 || m.out_data !== 40'd16000 || m.out_count !== 16'd16 || m.out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_group: valid=%0b data=%0d count=%0d ovf=%0b, required 1/16000/16/0",
               m.out_valid, m.out_data, m.out_count, m.out_ovf);
    end
    tests++;
    if (m.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_group_no_gap: in_ready=%0b, required 1", m.in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic        ok;
    logic [39:0] d;
    logic [15:0] c;
    logic        o;
    m.out_ready = 1'b0;
    m.in_valid  = 1'b1;
    m.in_data   = 32'd2;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      tests++;
      if (m.in_ready !== 1'b0 || m.out_valid !== 1'b1 || m.out_data !== 40'd16000 || m.out_count !== 16'd16) begin
        fails++;
        $display("[TB] FAIL backpressure_hold[%0d]: in_ready=%0b valid=%0b data=%0d count=%0d, required 0/1/16000/16",
                 i, m.in_ready, m.out_valid, m.out_data, m.out_count);
      end
    end
    m.out_ready = 1'b1;
    tick(1);
    idle_main();
    for (int i = 0; i < 15; i++) send(32'd2, 1'b0, 1'b0);
    tick(1);
    pop_total(ok, d, c, o);
    tests++;
    if (!ok || d !== 40'd16000 || c !== 16'd16 || o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL backpressure_first: present=%0b data=%0d count=%0d ovf=%0b, required 1/16000/16/0", ok, d, c, o);
    end
    pop_total(ok, d, c, o);
    tests++;
    if (!ok || d !== 40'd32 || c !== 16'd16 || o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL backpressure_second: present=%0b data=%0d count=%0d ovf=%0b, required 1/32/16/0", ok, d, c, o);
    end
  endtask

  task automatic test_flush();
    logic        ok;
    logic [39:0] d;
    logic [15:0] c;
    logic        o;
    send(32'd5, 1'b0, 1'b0);
    send(32'd7, 1'b0, 1'b0);
    send(32'd9, 1'b1, 1'b0);
    tick(1);
    pop_total(ok, d, c, o);
    tests++;
    if (!ok || d !== 40'd21 || c !== 16'd3 || o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_group: present=%0b data=%0d count=%0d ovf=%0b, required 1/21/3/0", ok, d, c, o);
    end
    m.flush = 1'b1;
    tick(3);
    m.flush = 1'b0;
    tick(1);
    tests++;
    if (q_data.size() != 0 || m.out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_idle: totals=%0d out_valid=%0b, required 0/0", q_data.size(), m.out_valid);
    end
  endtask

  task automatic test_clr();
    logic        ok;
    logic [39:0] d;
    logic [15:0] c;
    logic        o;
    for (int i = 0; i < 4; i++) send(32'd10, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) send(32'd1, 1'b0, 1'b0);
    tick(1);
    pop_total(ok, d, c, o);
    tests++;
    if (!ok || d !== 40'd17 || c !== 16'd16 || o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clr_restart: present=%0b data=%0d count=%0d ovf=%0b, required 1/17/16/0", ok, d, c, o);
    end
    for (int i = 0; i < 3; i++) send(32'd5, 1'b0, 1'b0);
    m.clr   = 1'b1;
    m.flush = 1'b1;
    tick(1);
    idle_main();
    tick(2);
    tests++;
    if (q_data.size() != 0 || m.out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clr_over_flush: totals=%0d out_valid=%0b, required 0/0", q_data.size(), m.out_valid);
    end
    for (int i = 0; i < 16; i++) send(32'd1, 1'b0, 1'b0);
    tick(1);
    pop_total(ok, d, c, o);
    tests++;
    if (!ok || d !== 40'd16 || c !== 16'd16 || o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clr_discard: present=%0b data=%0d count=%0d ovf=%0b, required 1/16/16/0", ok, d, c, o);
    end
  endtask

  task automatic test_reset_mid();
    logic        ok;
    logic [39:0] d;
    logic [15:0] c;
    logic        o;
    for (int i = 0; i < 5; i++) send(32'd7, 1'b0, 1'b0);
    resetn = 1'b0;
    #2;
    tests++;
    if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid_async: out_valid=%0b in_ready=%0b, required 0/1", m.out_valid, m.in_ready);
    end
    tick(2);
    resetn = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) send(32'd1, 1'b0, 1'b0);
    tick(1);
    pop_total(ok, d, c, o);
    tests++;
    if (!ok || d !== 40'd16 || c !== 16'd16 || o !== 1'b0 || q_data.size() != 0) begin
      fails++;
      $display("[TB] FAIL reset_mid_group: present=%0b data=%0d count=%0d ovf=%0b extra=%0d, required 1/16/16/0/0",
               ok, d, c, o, q_data.size());
    end
  endtask

  task automatic test_overflow();
    logic [32:0] exp3;
`ifdef ACCUM_SAT_EN
    exp3 = 33'h1_FFFF_FFFF;
`else
    exp3 = 33'h0_FFFF_FFFD;
`endif
    a.in_valid = 1'b1;
    a.in_data  = 32'hFFFF_FFFF;
    b.in_valid = 1'b1;
    b.in_data  = 32'hFFFF_FFFF;
    tick(2);
    tests++;
    if (a.out_valid !== 1'b1 || a.out_data !== 33'h1_FFFF_FFFE || a.out_count !== 16'd2 || a.out_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_len2: valid=%0b data=%0h count=%0d ovf=%0b, required 1/1fffffffe/2/0",
               a.out_valid, a.out_data, a.out_count, a.out_ovf);
    end
    tests++;
    if (b.out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_len3_early: valid=%0b, required 0", b.out_valid);
    end
    a.in_valid = 1'b0;
    tick(1);
    b.in_valid = 1'b0;
    tests++;
    if (b.out_valid !== 1'b1 || b.out_data !== exp3 || b.out_count !== 16'd3 || b.out_ovf !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovf_len3: valid=%0b data=%0h count=%0d ovf=%0b, required 1/%0h/3/1",
               b.out_valid, b.out_data, b.out_count, b.out_ovf, exp3);
    end
    tick(2);
  endtask

  // Test sequence
  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.flush = 1'b0; a.clr = 1'b0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_data = '0; b.flush = 1'b0; b.clr = 1'b0; b.out_ready = 1'b1;
    test_reset();
    test_full_group();
    test_backpressure();
    test_flush();
    test_clr();
    test_reset_mid();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
